pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Pipeline stall controller for the 5-stage MIPS core. It merges the load-use stall request from ID with multi-cycle EX operations such as DIV and MADD, and produces the per-stage stall vector consumed by pc_reg and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. A counter-driven FSM holds EX for the requested number of cycles, then releases it with a one-cycle done strobe. A saturating stall-cycle performance counter is included.

## Interface
- CNT_W, 6, width of the multi-cycle length input and of the internal down-counter.
- PERF_W, 16, width of the saturating stall-cycle counter.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_stallreq  in  1  load-use hazard from ID; level, valid every cycle.
- ex_start  in  1  the instruction in EX is multi-cycle; level, held while that instruction sits in EX.
- ex_cycles  in  CNT_W  number of stall cycles the EX op needs; sampled only when accepted; 0 means single-cycle, so there is no stall.
- flush  in  1  exception/cancel; aborts any multi-cycle op.
- perf_clr  in  1  synchronous clear of perf_cnt_o.
- stall_o  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 holds that stage.
- busy_o  out  1  FSM in RUN.
- done_o  out  1  EX multi-cycle result valid this cycle; the EX op advances.
- count_o  out  CNT_W  remaining stall cycles after the current one.
- perf_cnt_o  out  PERF_W  cycles with stall_o[0]=1, saturating.

## Operation
- States:
  - IDLE: no multi-cycle op in flight.
  - RUN: counting down.
  - DONE: one-cycle release.
- IDLE:
  - If ex_start=1, ex_cycles!=0 and flush=0, accept the op: stall_o=6'b001111 in the same cycle (combinational), and count<=ex_cycles-1.
  - Next state is DONE if ex_cycles==1, otherwise RUN.
  - If ex_start=1 and ex_cycles==0, ignore it: no stall from EX.
- RUN: stall_o=6'b001111; count<=count-1; when count==1, next state is DONE.
- DONE:
  - done_o=1 and no EX stall; ex_start is ignored because the same instruction is still presented.
  - Next state is always IDLE.
- Stall vector priority, highest first:
  1. rst: stall_o=0.
  2. flush: stall_o=0.
  3. EX stall, i.e. an op accepted in IDLE or in RUN: 6'b001111.
  4. id_stallreq: 6'b000111, which inserts a bubble into EX.
  5. Otherwise 0.
- id_stallreq during RUN is absorbed by the EX stall. During DONE, id_stallreq yields 6'b000111.
- flush in any state: next state IDLE, count<=0. done_o=0 and stall_o=0 in that cycle.
- ex_start and flush in the same IDLE cycle: the op is not accepted.
- count_o is a registered output.
- Total EX stall length is exactly ex_cycles cycles, followed by one DONE cycle.
- Perf counter update:
  - perf_clr=1: perf_cnt<=0. This has priority over increment.
  - Otherwise, if stall_o[0]=1 and perf_cnt!=all-ones: perf_cnt<=perf_cnt+1.
  - It holds at 2^PERF_W-1.
- Widths: count arithmetic is CNT_W-bit unsigned; ex_cycles max is 2^CNT_W-1 (63), so no wrap is possible.

## Timing
- Reset values: state IDLE, count_o=0, busy_o=0, done_o=0, stall_o=0, perf_cnt_o=0.
- stall_o and done_o are combinational from state, id_stallreq, ex_start, ex_cycles and flush. The stall takes effect in the same cycle as the request.
- busy_o is 1 in the cycle after acceptance and for every RUN cycle.
- Accept-to-done latency is ex_cycles cycles; done_o is on cycle ex_cycles after acceptance (acceptance = cycle 0).
- Back-to-back multi-cycle ops: DONE→IDLE, so a new op in EX is accepted on the cycle after DONE.
- rst asserted mid-RUN: next cycle is IDLE with all outputs at reset values.

## Test plan
- Reset: rst=1 for 2 cycles with ex_start=1, ex_cycles=5 → stall_o=0, busy_o=0, perf_cnt_o=0 throughout.
- ex_cycles=3 division:
  - ex_start=1 at cycle 0 → stall_o=6'b001111 on cycles 0–2.
  - count_o=2,1,0 on cycles 1–3.
  - done_o=1 and stall_o=0 on cycle 3; IDLE on cycle 4.
- ex_cycles=1 → stall on cycle 0 only; done_o on cycle 1. ex_cycles=0 → no stall, done_o never asserted.
- Load-use: id_stallreq=1 in IDLE → stall_o=6'b000111. id_stallreq=1 during RUN → 6'b001111. id_stallreq=1 in DONE → 6'b000111 with done_o=1.
- Flush: ex_cycles=10, flush=1 on cycle 4 → stall_o=0 and done_o=0 on cycle 4; IDLE and count_o=0 on cycle 5. Also drive flush and ex_start together in IDLE → op not accepted.
- Perf counter, with PERF_W=4:
  - 20 stall cycles → perf_cnt_o saturates at 15.
  - perf_clr together with a stall cycle → 0.
  - Then it counts 1 on the next stall cycle.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall controller.
interface pipe_stall_ctrl_if #(
   parameter int unsigned CNT_W  = 6,
   parameter int unsigned PERF_W = 16
);
   logic              id_stallreq;
   logic              ex_start;
   logic [CNT_W-1:0]  ex_cycles;
   logic              flush;
   logic              perf_clr;
   logic [5:0]        stall_o;
   logic              busy_o;
   logic              done_o;
   logic [CNT_W-1:0]  count_o;
   logic [PERF_W-1:0] perf_cnt_o;

   // Pipeline side: raises requests, consumes the stall vector.
   modport master (
      output id_stallreq, ex_start, ex_cycles, flush, perf_clr,
      input  stall_o, busy_o, done_o, count_o, perf_cnt_o
   );

   // Controller side.
   modport slave (
      input  id_stallreq, ex_start, ex_cycles, flush, perf_clr,
      output stall_o, busy_o, done_o, count_o, perf_cnt_o
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges the ID load-use stall with multi-cycle
// EX operations, produces the per-stage stall vector and counts stall cycles.
module pipe_stall_ctrl #(
   parameter int unsigned CNT_W  = 6,
   parameter int unsigned PERF_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   pipe_stall_ctrl_if.slave    bus
);

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_ID   = 6'b000111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              busy_q;
   logic [PERF_W-1:0] perf_q;
   logic              ex_stall;
   logic              done_c;
   logic [5:0]        stall_c;

   // State, remaining-cycle counter and busy flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         busy_q  <= (state_d == RUN);
      end
   end

   // Next state, counter update and combinational stall/done decode.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      ex_stall = 1'b0;
      done_c   = 1'b0;
      stall_c  = STALL_NONE;

      case (state_q)
         IDLE: begin
            // A zero-length op is single-cycle and never stalls.
            if (bus.ex_start && (bus.ex_cycles != '0)) begin
               ex_stall = 1'b1;
               count_d  = bus.ex_cycles - CNT_W'(1);
               state_d  = (bus.ex_cycles == CNT_W'(1)) ? DONE : RUN;
            end
         end
         RUN: begin
            ex_stall = 1'b1;
            count_d  = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // ex_start is still high for the finishing instruction; ignore it.
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase

      // Flush cancels any in-flight op and suppresses this cycle's stall.
      if (bus.flush) begin
         state_d  = IDLE;
         count_d  = '0;
         ex_stall = 1'b0;
         done_c   = 1'b0;
      end

      if (rst || bus.flush) begin
         stall_c = STALL_NONE;
      end else if (ex_stall) begin
         stall_c = STALL_EX;
      end else if (bus.id_stallreq) begin
         stall_c = STALL_ID;
      end

      if (rst) begin
         done_c = 1'b0;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
      end else if (bus.perf_clr) begin
         perf_q <= '0;
      end else if (stall_c[0] && (perf_q != '1)) begin
         perf_q <= perf_q + PERF_W'(1);
      end
   end

   assign bus.stall_o    = stall_c;
   assign bus.done_o     = done_c;
   assign bus.busy_o     = busy_q;
   assign bus.count_o    = count_q;
   assign bus.perf_cnt_o = perf_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a driver issues directed and random
// cycles and queues the expected outputs; a monitor pops and compares them.
module tb_pipe_stall_ctrl;

   localparam int unsigned CNT_W  = 6;
   localparam int unsigned PERF_W = 4;
   localparam int          PERF_MAX = (1 << PERF_W) - 1;

   typedef struct {
      logic [5:0]        stall;
      logic              done;
      logic              busy;
      logic [CNT_W-1:0]  count;
      logic [PERF_W-1:0] perf;
   } exp_t;

   logic clk;
   logic rst;

   pipe_stall_ctrl_if #(.CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();

   pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: an accepted op owes 'left' more stall cycles, after
   // which one release cycle is owed. Registered outputs are remembered.
   int m_left    = 0;
   bit m_release = 1'b0;
   int m_count   = 0;
   bit m_busy    = 1'b0;
   int m_perf    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs the model predicts.
   task automatic cyc(input bit r, input bit id, input bit st, input int n,
                      input bit fl, input bit clr);
      exp_t e;
      bit   ex;
      bit   dn;
      logic [5:0] stl;
      @(posedge clk);
      #1;
      rst             = r;
      bus.id_stallreq = id;
      bus.ex_start    = st;
      bus.ex_cycles   = CNT_W'(n);
      bus.flush       = fl;
      bus.perf_clr    = clr;

      e.busy  = m_busy;
      e.count = CNT_W'(m_count);
      e.perf  = PERF_W'(m_perf);

      ex = 1'b0;
      dn = 1'b0;
      if (m_release) begin
         dn = 1'b1;
         m_release = 1'b0;
      end else if (m_left > 0) begin
         ex = 1'b1;
         m_left--;
         if (m_left == 0) m_release = 1'b1;
      end else if (st && n > 0) begin
         ex = 1'b1;
         m_left = n - 1;
         if (m_left == 0) m_release = 1'b1;
      end

      if (r || fl) begin
         stl = 6'b000000;
         dn  = 1'b0;
         m_left = 0;
         m_release = 1'b0;
      end else if (ex) begin
         stl = 6'b001111;
      end else if (id) begin
         stl = 6'b000111;
      end else begin
         stl = 6'b000000;
      end
      e.stall = stl;
      e.done  = dn;

      if (r) begin
         m_count = 0;
         m_busy  = 1'b0;
         m_perf  = 0;
      end else begin
         m_count = m_left;
         m_busy  = (m_left > 0);
         if (clr) m_perf = 0;
         else if (stl[0] && m_perf < PERF_MAX) m_perf++;
      end
      exp_q.push_back(e);
   endtask

   // Monitor: compare every queued expectation mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("stall_o",    32'(bus.stall_o),    32'(e.stall));
         chk("done_o",     32'(bus.done_o),     32'(e.done));
         chk("busy_o",     32'(bus.busy_o),     32'(e.busy));
         chk("count_o",    32'(bus.count_o),    32'(e.count));
         chk("perf_cnt_o", 32'(bus.perf_cnt_o), 32'(e.perf));
      end
   end

   initial begin
      rst             = 1'b1;
      bus.id_stallreq = 1'b0;
      bus.ex_start    = 1'b1;
      bus.ex_cycles   = CNT_W'(5);
      bus.flush       = 1'b0;
      bus.perf_clr    = 1'b0;

      // Reset held with a pending op.
      repeat (2) cyc(1, 0, 1, 5, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // Three-cycle op held in EX until done, then released.
      repeat (4) cyc(0, 0, 1, 3, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 0, 0);

      // One-cycle and zero-cycle ops.
      repeat (2) cyc(0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 1, 0, 0, 0);

      // Load-use in IDLE, during RUN and in DONE.
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 2, 0, 0);
      cyc(0, 1, 1, 2, 0, 0);
      cyc(0, 1, 1, 2, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // Flush on cycle 4 of a ten-cycle op, then flush with start in IDLE.
      repeat (4) cyc(0, 0, 1, 10, 0, 0);
      cyc(0, 0, 1, 10, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 4, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // Back-to-back ops.
      repeat (8) cyc(0, 0, 1, 2, 0, 0);

      // Reset in the middle of a long op.
      repeat (3) cyc(0, 0, 1, 20, 0, 0);
      cyc(1, 0, 1, 20, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // Perf saturation, clear during a stall, then count again.
      repeat (20) cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         bit r, id, st, fl, clr;
         int n;
         r   = ($urandom_range(0, 149) == 0);
         fl  = ($urandom_range(0, 24) == 0);
         clr = ($urandom_range(0, 39) == 0);
         id  = ($urandom_range(0, 3) == 0);
         st  = ($urandom_range(0, 2) != 0);
         n   = ($urandom_range(0, 19) == 0) ? 63 : int'($urandom_range(0, 7));
         cyc(r, id, st, n, fl, clr);
      end
      cyc(0, 0, 0, 0, 0, 0);

      // Let the monitor drain the queue, bounded.
      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
